// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: decodes the ring-counter T-state and opcode into the
// 12-bit control word, requests early ring resets, and latches halt, bad-T and retire state.
module sap1_controller #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic [5:0]       t,
  input  logic [3:0]       op,
  output logic [11:0]      ctrl,
  output logic             ring_clr,
  output logic             hlt,
  output logic             t_err,
  output logic [CNT_W-1:0] icount
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  logic        t_ok;
  logic        is_lda;
  logic        is_add;
  logic        is_sub;
  logic        is_out;
  logic        is_hlt;
  logic        mem_op;
  logic        last_state;
  logic        run_ok;
  logic [11:0] micro;
  logic        micro_clr;

  // A valid T-state has exactly one bit set: nonzero and clearing its lowest set bit leaves zero.
  assign t_ok   = (t != 6'd0) && ((t & (t - 6'd1)) == 6'd0);

  assign is_lda = (op == OP_LDA);
  assign is_add = (op == OP_ADD);
  assign is_sub = (op == OP_SUB);
  assign is_out = (op == OP_OUT);
  assign is_hlt = (op == OP_HLT);
  assign mem_op = is_lda | is_add | is_sub;

  assign last_state = (t[3] & ~mem_op) | (t[4] & is_lda) | (t[5] & (is_add | is_sub));
  assign run_ok     = t_ok & ~t_err & ~hlt;

  always_comb begin
    micro     = 12'h000;
    micro_clr = 1'b0;
    if (t[0]) begin
      micro = EP | LM;
    end else if (t[1]) begin
      micro = CP;
    end else if (t[2]) begin
      micro = CE | LI;
    end else if (t[3]) begin
      if (mem_op) begin
        micro = EI | LM;
      end else if (is_out) begin
        micro     = EA | LO;
        micro_clr = 1'b1;
      end else begin
        micro_clr = 1'b1;
      end
    end else if (t[4]) begin
      if (is_lda) begin
        micro     = CE | LA;
        micro_clr = 1'b1;
      end else if (is_add | is_sub) begin
        micro = CE | LB;
      end
    end else if (t[5]) begin
      if (is_add) begin
        micro = EU | LA;
      end else if (is_sub) begin
        micro = SU | EU | LA;
      end
    end
  end

  // Reset, a malformed T-state or a latched fault all park the datapath with the ring held at T1.
  always_comb begin
    ctrl     = 12'h000;
    ring_clr = 1'b1;
    if (res && run_ok) begin
      ctrl     = micro;
      ring_clr = micro_clr;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      hlt    <= 1'b0;
      t_err  <= 1'b0;
      icount <= '0;
    end else begin
      if (!t_ok) begin
        t_err <= 1'b1;
      end
      if (run_ok) begin
        if (last_state) begin
          icount <= icount + 1'b1;
        end
        if (t[3] && is_hlt) begin
          hlt <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Randomized scoreboard bench for sap1_controller: stimulus emulates the ring counter and
// queues model predictions; a monitor compares the DUT one tick after each posedge.
module tb_sap1_controller;

  localparam int CNT_W = 8;

  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUTI = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;

  logic             clk = 1'b0;
  logic             res;
  logic [5:0]       t;
  logic [3:0]       op;
  logic [11:0]      ctrl;
  logic             ring_clr;
  logic             hlt;
  logic             t_err;
  logic [CNT_W-1:0] icount;

  typedef struct {
    logic [11:0] ctrl;
    logic        clr;
    logic        hlt;
    logic        err;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mHlt;
  bit   mErr;
  int   mCount;

  sap1_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .t(t), .op(op), .ctrl(ctrl),
    .ring_clr(ring_clr), .hlt(hlt), .t_err(t_err), .icount(icount)
  );

  always #5 clk = ~clk;

  // Instruction length in T-states, straight from the instruction set summary.
  function automatic int instrLen(input logic [3:0] o);
    if (o == LDA) return 5;
    if (o == ADD || o == SUB) return 6;
    return 4;
  endfunction

  function automatic logic [11:0] microWord(input int k, input logic [3:0] o);
    case (k)
      1: return EP | LM;
      2: return CP;
      3: return CE | LI;
      4: begin
        if (o == LDA || o == ADD || o == SUB) return EI | LM;
        if (o == OUTI) return EA | LO;
        return 12'h000;
      end
      5: begin
        if (o == LDA) return CE | LA;
        if (o == ADD || o == SUB) return CE | LB;
        return 12'h000;
      end
      6: begin
        if (o == ADD) return EU | LA;
        if (o == SUB) return SU | EU | LA;
        return 12'h000;
      end
      default: return 12'h000;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one T-state after the falling edge and queues what the DUT must show after the next rising edge.
  task automatic applyStimulus(input logic [5:0] tv, input logic [3:0] ov, input logic rv,
                               output bit clrOut);
    exp_t e;
    int   k;
    int   ones;
    @(negedge clk);
    #1;
    t   = tv;
    op  = ov;
    res = rv;
    k    = 0;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      if (tv[i]) begin
        ones++;
        k = i + 1;
      end
    end
    if (!rv) begin
      mHlt   = 1'b0;
      mErr   = 1'b0;
      mCount = 0;
      e.ctrl = 12'h000;
      e.clr  = 1'b1;
    end else if (ones != 1 || mHlt || mErr) begin
      e.ctrl = 12'h000;
      e.clr  = 1'b1;
      if (ones != 1) mErr = 1'b1;
    end else begin
      e.ctrl = microWord(k, ov);
      e.clr  = (k == instrLen(ov)) && (k != 6);
      if (k == instrLen(ov)) mCount = (mCount + 1) % (1 << CNT_W);
      if (ov == HLT && k == 4) mHlt = 1'b1;
    end
    e.hlt = mHlt;
    e.err = mErr;
    e.cnt = mCount;
    q.push_back(e);
    clrOut = e.clr;
  endtask

  // Steps the emulated ring counter through one instruction until it clears or wraps.
  task automatic runInstr(input logic [3:0] ov);
    int k;
    bit clr;
    bit done;
    k = 1;
    done = 1'b0;
    while (!done) begin
      applyStimulus(6'(1 << (k - 1)), ov, 1'b1, clr);
      done = clr || (k == 6);
      k++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checkOutput("ctrl", 32'(ctrl), 32'(e.ctrl));
        checkOutput("ring_clr", 32'(ring_clr), 32'(e.clr));
        checkOutput("hlt", 32'(hlt), 32'(e.hlt));
        checkOutput("t_err", 32'(t_err), 32'(e.err));
        checkOutput("icount", 32'(icount), 32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d checks so far", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    bit          clr;
    int          sel;
    logic [3:0]  rop;
    int          waitCycles;
    res = 1'b1;
    t   = 6'b000001;
    op  = 4'b0000;
    mHlt = 1'b0;
    mErr = 1'b0;
    mCount = 0;

    #1 res = 1'b0;
    #1;
    checkOutput("reset_ctrl", 32'(ctrl), 32'h0);
    checkOutput("reset_ring_clr", 32'(ring_clr), 32'h1);
    checkOutput("reset_hlt", 32'(hlt), 32'h0);
    checkOutput("reset_t_err", 32'(t_err), 32'h0);
    checkOutput("reset_icount", 32'(icount), 32'h0);
    applyStimulus(6'b000100, ADD, 1'b0, clr);
    applyStimulus(6'b000001, ADD, 1'b0, clr);

    // Directed pass over every instruction class.
    runInstr(ADD);
    runInstr(LDA);
    runInstr(SUB);
    runInstr(OUTI);
    runInstr(4'b0111);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: rop = LDA;
        1: rop = ADD;
        2: rop = SUB;
        3: rop = OUTI;
        default: rop = 4'($urandom_range(3, 13));
      endcase
      runInstr(rop);
    end

    $display("[TB] malformed T-state");
    applyStimulus(6'b000011, ADD, 1'b1, clr);
    applyStimulus(6'b000001, LDA, 1'b1, clr);
    applyStimulus(6'b000010, LDA, 1'b1, clr);
    applyStimulus(6'b000100, LDA, 1'b1, clr);
    applyStimulus(6'b010000, LDA, 1'b1, clr);
    applyStimulus(6'b000001, LDA, 1'b0, clr);
    runInstr(OUTI);
    // Bad vector that also includes T4 of a retiring NOP must not count.
    applyStimulus(6'b001001, 4'b0111, 1'b1, clr);
    applyStimulus(6'b001000, 4'b0111, 1'b1, clr);
    applyStimulus(6'b000000, 4'b0111, 1'b1, clr);
    applyStimulus(6'b000001, 4'b0111, 1'b0, clr);

    $display("[TB] counter wrap");
    for (int n = 0; n < 255; n++) runInstr(4'b1000);
    settle();
    checkOutput("icount_255", 32'(icount), 32'd255);
    runInstr(4'b1000);
    settle();
    checkOutput("icount_wrap", 32'(icount), 32'd0);

    $display("[TB] halt");
    runInstr(LDA);
    runInstr(HLT);
    for (int k = 1; k <= 6; k++) applyStimulus(6'(1 << (k - 1)), 4'($urandom_range(0, 15)), 1'b1, clr);
    runInstr(ADD);
    applyStimulus(6'b000001, ADD, 1'b0, clr);
    runInstr(OUTI);

    $display("[TB] reset during ADD T5");
    runInstr(LDA);
    applyStimulus(6'b000001, ADD, 1'b1, clr);
    applyStimulus(6'b000010, ADD, 1'b1, clr);
    applyStimulus(6'b000100, ADD, 1'b1, clr);
    applyStimulus(6'b001000, ADD, 1'b1, clr);
    @(negedge clk);
    #1 t = 6'b010000;
    #1;
    checkOutput("add_t5_ctrl", 32'(ctrl), 32'h102);
    checkOutput("add_t5_ring_clr", 32'(ring_clr), 32'h0);
    checkOutput("pre_reset_icount", 32'(icount), 32'(mCount));
    res = 1'b0;
    mHlt = 1'b0;
    mErr = 1'b0;
    mCount = 0;
    #1;
    checkOutput("midreset_icount", 32'(icount), 32'h0);
    checkOutput("midreset_ctrl", 32'(ctrl), 32'h0);
    checkOutput("midreset_ring_clr", 32'(ring_clr), 32'h1);
    applyStimulus(6'b000001, ADD, 1'b0, clr);
    runInstr(ADD);
    runInstr(SUB);

    waitCycles = 0;
    while (q.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
